// File: rtl/vis_frame_reader.sv
// Visibility frame sink: captures PAIRS {re,im} beats per frame into a ping-pong SRAM,
// checks framing, and replays each committed frame as a byte stream.
module vis_frame_reader #(
    parameter int CORES = 18,
    parameter int TRATE = 30,
    parameter int NBITS = 5,
    parameter int TBITS = 5,
    parameter int WIDTH = 36
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] revis_i,
    input  logic [WIDTH-1:0] imvis_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             last_i,
    output logic [7:0]       tdata_o,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic             tlast_o,
    output logic             err_o
);
    // state  | meaning
    // W_FILL | storing beats of the current frame into bank wsel
    // W_DROP | overlong frame, discarding beats until last_i
    // R_IDLE | waiting for bank rsel to be committed
    // R_SEND | streaming bank rsel out byte by byte
    localparam int PAIRS = CORES * TRATE;
    localparam int PBITS = NBITS + TBITS;
    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int NB    = 2 * BYTES;
    localparam int BBITS = $clog2(NB);
    localparam int AW    = PBITS + 1;
    localparam logic [PBITS-1:0] LAST_IDX   = PBITS'(PAIRS - 1);
    localparam logic [BBITS-1:0] LAST_BYTE  = BBITS'(NB - 1);
    localparam logic [AW-1:0]    BANK1_BASE = AW'(PAIRS);

    typedef enum logic {W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    wstate_t wstate, wstate_n;
    rstate_t rstate, rstate_n;

    logic [1:0]         full;
    logic               wsel, rsel;
    logic [PBITS-1:0]   windex, rindex, rnext;
    logic [BBITS-1:0]   bidx;
    logic [2*WIDTH-1:0] mem [2*PAIRS];
    logic [2*WIDTH-1:0] rdata;
    logic [AW-1:0]      waddr, raddr;
    logic [16*BYTES-1:0] pair_bytes;
    logic [7:0]         cur_byte;

    logic accept, wr_en, w_at_end, commit, err_evt;
    logic start, load, rel, prefetch, rd_en;

    // write FSM
    always_ff @(posedge clock_i) begin
        if (reset_i) wstate <= W_FILL;
        else         wstate <= wstate_n;
    end

    always_comb begin
        wstate_n = wstate;
        case (wstate)
            W_FILL:  if (wr_en && w_at_end && !last_i) wstate_n = W_DROP;
            W_DROP:  if (accept && last_i) wstate_n = W_FILL;
            default: wstate_n = W_FILL;
        endcase
    end

    always_comb begin
        ready_o  = !reset_i && ((wstate == W_DROP) || !(full[0] && full[1]));
        accept   = valid_i && ready_o;
        wr_en    = accept && (wstate == W_FILL);
        w_at_end = (windex == LAST_IDX);
        commit   = wr_en && last_i && w_at_end;
        err_evt  = wr_en && (last_i != w_at_end);
    end

    // read FSM
    always_ff @(posedge clock_i) begin
        if (reset_i) rstate <= R_IDLE;
        else         rstate <= rstate_n;
    end

    always_comb begin
        rstate_n = rstate;
        case (rstate)
            R_IDLE:  if (full[rsel]) rstate_n = R_SEND;
            R_SEND:  if (rel) rstate_n = R_IDLE;
            default: rstate_n = R_IDLE;
        endcase
    end

    always_comb begin
        start    = (rstate == R_IDLE) && full[rsel];
        load     = (rstate == R_SEND) && (!tvalid_o || tready_i) && !tlast_o;
        rel      = (rstate == R_SEND) && tvalid_o && tready_i && tlast_o;
        prefetch = load && (bidx == LAST_BYTE) && (rindex != LAST_IDX);
        rd_en    = start || prefetch;
    end

    // next pair is fetched while the last byte of the current one goes out
    assign rnext      = start ? '0 : rindex + PBITS'(1);
    assign waddr      = wsel ? BANK1_BASE + AW'(windex) : AW'(windex);
    assign raddr      = rsel ? BANK1_BASE + AW'(rnext) : AW'(rnext);
    assign pair_bytes = {(8*BYTES)'(rdata[WIDTH-1:0]), (8*BYTES)'(rdata[2*WIDTH-1:WIDTH])};
    assign cur_byte   = pair_bytes[{bidx, 3'b000} +: 8];

    always_ff @(posedge clock_i) begin
        if (wr_en) mem[waddr] <= {revis_i, imvis_i};
        if (rd_en) rdata <= mem[raddr];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            windex <= '0;
            wsel   <= 1'b0;
            full   <= 2'b00;
            err_o  <= 1'b0;
        end else begin
            err_o <= err_evt;
            if (wr_en) windex <= (last_i || w_at_end) ? '0 : windex + PBITS'(1);
            if (commit) begin
                wsel       <= !wsel;
                full[wsel] <= 1'b1;
            end
            // commit and release always target different banks
            if (rel) full[rsel] <= 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rsel     <= 1'b0;
            rindex   <= '0;
            bidx     <= '0;
            tdata_o  <= 8'h00;
            tvalid_o <= 1'b0;
            tlast_o  <= 1'b0;
        end else begin
            if (start) begin
                rindex <= '0;
                bidx   <= '0;
            end else if (load) begin
                if (bidx == LAST_BYTE) begin
                    bidx <= '0;
                    if (prefetch) rindex <= rindex + PBITS'(1);
                end else begin
                    bidx <= bidx + BBITS'(1);
                end
            end
            if (rel) rsel <= !rsel;
            if (load) begin
                tdata_o  <= cur_byte;
                tvalid_o <= 1'b1;
                tlast_o  <= (rindex == LAST_IDX) && (bidx == LAST_BYTE);
            end else if (tready_i) begin
                tvalid_o <= 1'b0;
                tlast_o  <= 1'b0;
            end
        end
    end
endmodule
